cfg_req_master: RTL and testbench
=================================

CFG_REQ_MASTER -- requirements
Module: cfg_req_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RD_TIMEOUT, default 16, max cycles waited for rdata_vld after rd.
REQ-003 SHALL have the following ports:
  - clk  in  1  sole clock; all logic on its rising edge.
  - rst  in  1  asynchronous, active-high reset.
  - req_valid  in  1  request offered.
  - req_ready  out  1  request FIFO not full.
  - req_wr  in  1  1=write, 0=read.
  - req_addr  in  32  register address.
  - req_wdata  in  32  write data; ignored for reads.
  - rsp_valid  out  1  response available.
  - rsp_ready  in  1  consumer accepts response.
  - rsp_rdata  out  32  read data; 0 for writes.
  - rsp_err  out  1  read timed out.
  - addr  out  32  config-bus address.
  - wdata  out  32  config-bus write data.
  - wr  out  1  config-bus write strobe, one cycle.
  - rd  out  1  config-bus read strobe, one cycle.
  - rdata  in  32  config-bus read data.
  - rdata_vld  in  1  config-bus read data valid.

Function
REQ-004 SHALL accept a request when req_valid && req_ready; the FIFO stores {wr, addr, wdata}.
REQ-005 SHALL deassert req_ready exactly when FIFO holds FIFO_DEPTH entries; simultaneous push and pop when full SHALL NOT be accepted (ready low).
REQ-006 SHALL implement FSM IDLE, ISSUE, WAIT_RD, RESP.
REQ-007 IDLE -> ISSUE when FIFO non-empty; the entry is popped and registered on that transition.
REQ-008 ISSUE SHALL last one cycle, driving addr/wdata and a single wr or rd pulse; write -> RESP, read -> WAIT_RD.
REQ-009 addr and wdata SHALL hold their last issued value outside ISSUE; wr and rd SHALL never be high together.
REQ-010 WAIT_RD: rdata_vld high captures rdata into rsp_rdata with rsp_err=0, then -> RESP; rdata_vld in the ISSUE cycle is also accepted.
REQ-011 WAIT_RD: a counter starting at 0 in the cycle after ISSUE SHALL increment each cycle; if it reaches RD_TIMEOUT without rdata_vld, rsp_rdata=32'hDEAD_BEEF, rsp_err=1, -> RESP.
REQ-012 rdata_vld in IDLE, RESP or ISSUE of a write SHALL be ignored.
REQ-013 RESP: rsp_valid=1; payload SHALL stay stable until rsp_ready; on rsp_valid && rsp_ready -> IDLE.
REQ-014 Write responses SHALL carry rsp_rdata=0, rsp_err=0.
REQ-015 Throughput: one transaction in flight; min write turnaround 3 cycles from FIFO non-empty to response accepted with rsp_ready held high.
REQ-016 Requests SHALL complete strictly in acceptance order.

Reset
REQ-017 While rst=1: FSM=IDLE, FIFO empty, counter=0, req_ready=1 (after reset), rsp_valid=0, rsp_rdata=0, rsp_err=0, addr=0, wdata=0, wr=0, rd=0.
REQ-018 rst asserted mid-transaction SHALL discard FIFO contents and any in-flight transaction; no response is produced for them.

Structure
REQ-019 Shared package cfg_pkg SHALL hold the FSM state typedef, the 32-bit bus width constant and the timeout data constant 32'hDEAD_BEEF.
REQ-020 The request FIFO SHALL be the sub-module cfg_req_fifo (sync, parameterised width/depth); FSM and counter live in cfg_req_master.

Verification
REQ-021 Write addr=0x8, wdata=0x1234_5678 -> one-cycle wr with addr=0x8/wdata=0x1234_5678, then rsp_valid with rsp_rdata=0, rsp_err=0.
REQ-022 Read addr=0x14, slave returns rdata=0xCAFE_0001 three cycles after rd -> one rd pulse, rsp_rdata=0xCAFE_0001, rsp_err=0.
REQ-023 Read with slave silent -> rsp_valid exactly RD_TIMEOUT+1 cycles after the rd cycle, rsp_rdata=0xDEAD_BEEF, rsp_err=1.
REQ-024 rsp_ready held low, push 5 requests with FIFO_DEPTH=4 -> req_ready low after 4 FIFO entries plus 1 in flight; then release rsp_ready -> 5 in-order responses, no lost or duplicated strobes.
REQ-025 Assert rst during WAIT_RD with 2 queued requests -> all outputs at reset values next cycle, no further wr/rd strobes; a later rdata_vld is ignored.
REQ-026 Pulse rdata_vld=1 with rdata=0x55 while IDLE, then issue read returning 0x66 -> single response with rsp_rdata=0x66.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration-bus request master.
// Holds the FSM state encoding, bus width and the read-timeout filler word.
package cfg_pkg;

    localparam int CFG_BUS_W = 32;
    localparam logic [CFG_BUS_W-1:0] CFG_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } cfg_state_t;

    typedef struct packed {
        logic                 wr;
        logic [CFG_BUS_W-1:0] addr;
        logic [CFG_BUS_W-1:0] wdata;
    } cfg_req_t;

    localparam int CFG_REQ_W = $bits(cfg_req_t);

endpackage

// File: rtl/cfg_req_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending config requests.
// Push is refused while full, pop is refused while empty.
module cfg_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/cfg_req_master.sv
// Config-bus request master: queues requests, issues one bus strobe at a time,
// waits (bounded) for read data and returns an in-order response.
module cfg_req_master
    import cfg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [CFG_BUS_W-1:0] req_addr,
    input  logic [CFG_BUS_W-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CFG_BUS_W-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [CFG_BUS_W-1:0] addr,
    output logic [CFG_BUS_W-1:0] wdata,
    output logic                 wr,
    output logic                 rd,
    input  logic [CFG_BUS_W-1:0] rdata,
    input  logic                 rdata_vld
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

    cfg_state_t     state_r;
    logic [TW-1:0]  tmo_cnt_r;
    logic           cur_wr_r;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           fifo_push_s;
    logic           fifo_pop_s;
    cfg_req_t       push_req_s;
    cfg_req_t       head_s;

    assign req_ready   = !fifo_full_s;
    assign fifo_push_s = req_valid && !fifo_full_s;
    assign fifo_pop_s  = (state_r == ST_IDLE) && !fifo_empty_s;
    assign push_req_s  = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

    cfg_req_fifo #(
        .WIDTH (CFG_REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data (push_req_s),
        .full      (fifo_full_s),
        .pop       (fifo_pop_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s)
    );

    // Transaction FSM with read-timeout counter; all bus and response outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= {TW{1'b0}};
            cur_wr_r  <= 1'b0;
            addr      <= {CFG_BUS_W{1'b0}};
            wdata     <= {CFG_BUS_W{1'b0}};
            wr        <= 1'b0;
            rd        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= {CFG_BUS_W{1'b0}};
            rsp_err   <= 1'b0;
        end else begin
            wr <= 1'b0;
            rd <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r  <= ST_ISSUE;
                        cur_wr_r <= head_s.wr;
                        addr     <= head_s.addr;
                        wr       <= head_s.wr;
                        rd       <= ~head_s.wr;
                        // Reads leave wdata untouched so the bus keeps its last write value.
                        if (head_s.wr) begin
                            wdata <= head_s.wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt_r <= {TW{1'b0}};
                    if (cur_wr_r) begin
                        rsp_rdata <= {CFG_BUS_W{1'b0}};
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RESP;
                    end else if (rdata_vld) begin
                        rsp_rdata <= rdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RESP;
                    end else begin
                        state_r   <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (rdata_vld) begin
                        rsp_rdata <= rdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RESP;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        rsp_rdata <= CFG_TIMEOUT_DATA;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_req_master.sv
// Scoreboard bench for cfg_req_master: stimulus pushes expected strobes and
// responses into queues, a forked monitor pops and compares them.
module tb_cfg_req_master;

    localparam int TMO = 16;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } bus_t;

    typedef struct {
        logic [31:0] r;
        logic        e;
        int          lat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] rdata = 32'h0;
    logic        rdata_vld = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic        slv_en    = 1'b0;
    int          slv_delay = 1;
    logic [31:0] slv_base  = 32'h0;
    logic        man_vld   = 1'b0;
    logic [31:0] man_data  = 32'h0;
    int          slv_cnt   = 0;
    logic        slv_pend  = 1'b0;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;

    cfg_req_master #(
        .FIFO_DEPTH (4),
        .RD_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .addr      (addr),
        .wdata     (wdata),
        .wr        (wr),
        .rd        (rd),
        .rdata     (rdata),
        .rdata_vld (rdata_vld)
    );

    // Slave model: answers a read slv_delay cycles after rd with slv_base ^ addr.
    always @(posedge clk) begin
        #1;
        rdata_vld = 1'b0;
        rdata     = 32'h0;
        if (rd) begin
            slv_pend = slv_en;
            slv_cnt  = slv_delay;
        end else if (slv_pend) begin
            slv_cnt = slv_cnt - 1;
            if (slv_cnt == 0) begin
                rdata_vld = 1'b1;
                rdata     = slv_base ^ addr;
                slv_pend  = 1'b0;
            end
        end
        if (man_vld) begin
            rdata_vld = 1'b1;
            rdata     = man_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic monitor();
        int          cyc = 0;
        int          rd_cyc = 0;
        int          rise_cyc = 0;
        logic        prev_v = 1'b0;
        logic        prev_acc = 1'b0;
        logic [31:0] prev_d = 32'h0;
        logic        prev_e = 1'b0;
        bus_t        b;
        rsp_t        r;
        forever begin
            @(negedge clk);
            cyc++;
            if (wr || rd) begin
                chk1("strobe_exclusive", wr && rd, 1'b0);
                if (bus_q.size() == 0) begin
                    chk("unexpected_strobe_addr", addr, 32'hFFFF_FFFF);
                end else begin
                    b = bus_q.pop_front();
                    chk1("strobe_wr", wr, b.w);
                    chk1("strobe_rd", rd, ~b.w);
                    chk("strobe_addr", addr, b.a);
                    if (b.w) begin
                        chk("strobe_wdata", wdata, b.d);
                    end
                end
                if (rd) begin
                    rd_cyc = cyc;
                end
            end
            if (rsp_valid && !prev_v) begin
                rise_cyc = cyc;
            end
            if (rsp_valid && prev_v && !prev_acc) begin
                chk("rsp_stable_rdata", rsp_rdata, prev_d);
                chk1("rsp_stable_err", rsp_err, prev_e);
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.r);
                    chk1("rsp_err", rsp_err, r.e);
                    if (r.lat != 0) begin
                        chk("rsp_latency", 32'(rise_cyc - rd_cyc), 32'(r.lat));
                    end
                end
            end
            prev_v   = rsp_valid;
            prev_acc = rsp_valid && rsp_ready;
            prev_d   = rsp_rdata;
            prev_e   = rsp_err;
        end
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic track, input logic [31:0] er, input logic ee, input int lat);
        bus_t b;
        rsp_t r;
        int   n;
        req_valid = 1'b1;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        if (track) begin
            b.w = w; b.a = a; b.d = d;
            bus_q.push_back(b);
            r.r = er; r.e = ee; r.lat = lat;
            rsp_q.push_back(r);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        chk1("push_accept", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((bus_q.size() != 0 || rsp_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_drain_pending"}, 32'(bus_q.size() + rsp_q.size()), 32'h0);
    endtask

    task automatic check_idle_outputs();
        chk1("idle_rsp_valid", rsp_valid, 1'b0);
        chk("idle_rsp_rdata", rsp_rdata, 32'h0);
        chk1("idle_rsp_err", rsp_err, 1'b0);
        chk("idle_addr", addr, 32'h0);
        chk("idle_wdata", wdata, 32'h0);
        chk1("idle_wr", wr, 1'b0);
        chk1("idle_rd", rd, 1'b0);
        chk1("idle_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_idle_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("ready_after_rst", req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single write
        push(1'b1, 32'h8, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 0);
        drain("write");
        chk("addr_hold", addr, 32'h8);
        chk("wdata_hold", wdata, 32'h1234_5678);

        // Read answered three cycles after rd
        slv_en = 1'b1; slv_delay = 3; slv_base = 32'hCAFE_0015;
        push(1'b0, 32'h14, 32'h0, 1'b1, 32'hCAFE_0001, 1'b0, 4);
        drain("read");

        // Silent slave: timeout
        slv_en = 1'b0;
        push(1'b0, 32'h20, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, TMO + 1);
        drain("timeout");

        // Stray rdata_vld while idle, then a real read
        @(negedge clk);
        man_vld = 1'b1; man_data = 32'h55;
        @(negedge clk);
        man_vld = 1'b0;
        wait_cycles(3);
        chk1("stray_vld_no_rsp", rsp_valid, 1'b0);
        slv_en = 1'b1; slv_delay = 2; slv_base = 32'h56;
        push(1'b0, 32'h30, 32'h0, 1'b1, 32'h66, 1'b0, 3);
        drain("stray");

        // Back-pressure: fill FIFO with one transaction in flight
        rsp_ready = 1'b0;
        slv_delay = 1; slv_base = 32'hA5A5_0000;
        push(1'b1, 32'h40, 32'h11, 1'b1, 32'h0, 1'b0, 0);
        push(1'b0, 32'h44, 32'h0, 1'b1, 32'hA5A5_0044, 1'b0, 0);
        push(1'b1, 32'h48, 32'h22, 1'b1, 32'h0, 1'b0, 0);
        push(1'b0, 32'h4C, 32'h0, 1'b1, 32'hA5A5_004C, 1'b0, 0);
        chk1("ready_three_queued", req_ready, 1'b1);
        push(1'b1, 32'h50, 32'h33, 1'b1, 32'h0, 1'b0, 0);
        chk1("ready_low_full", req_ready, 1'b0);
        wait_cycles(3);
        chk1("ready_low_held", req_ready, 1'b0);
        chk1("rsp_pending", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        drain("backpressure");

        // Reset during WAIT_RD with two queued writes
        slv_en = 1'b0;
        push(1'b0, 32'h60, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 0);
        push(1'b1, 32'h64, 32'hAA, 1'b0, 32'h0, 1'b0, 0);
        push(1'b1, 32'h68, 32'hBB, 1'b0, 32'h0, 1'b0, 0);
        wait_cycles(3);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs();
        chk("rd_strobe_seen", 32'(bus_q.size()), 32'h0);
        rsp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        man_vld = 1'b1; man_data = 32'h77;
        @(negedge clk);
        man_vld = 1'b0;
        wait_cycles(30);
        chk1("post_rst_no_rsp", rsp_valid, 1'b0);
        chk("post_rst_rsp_rdata", rsp_rdata, 32'h0);
        chk1("post_rst_ready", req_ready, 1'b1);

        chk("final_bus_q", 32'(bus_q.size()), 32'h0);
        chk("final_rsp_q", 32'(rsp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
